// File: rtl/types_pkg.sv
// Shared types, funct3 encodings and access-decoding helpers for the load/store unit.
package types_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Unsupported encodings, misalignment, and simultaneous read+write all fault.
  function automatic logic access_illegal(input logic rd, input logic wr,
                                          input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (rd && wr) begin
      bad = 1'b1;
    end else begin
      case (f3)
        F3_LB:   bad = 1'b0;
        F3_LH:   bad = off[0];
        F3_LW:   bad = (off != 2'b00);
        F3_LBU:  bad = wr;
        F3_LHU:  bad = wr | off[0];
        default: bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      F3_SB[1:0]: be = 4'b0001 << off;
      F3_SH[1:0]: be = 4'b0011 << {off[1], 1'b0};
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide data-memory request/grant/response bus between the LSU and memory.
interface load_store_unit_if #(
  parameter int unsigned XLEN = types_pkg::XLEN
);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [3:0]      dmem_be;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_extend
  import types_pkg::*;
#(
  parameter int unsigned XLEN = types_pkg::XLEN
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] ext_data_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c     = rdata[{offset, 3'b000} +: 8];
    half_c     = rdata[{offset[1], 4'b0000} +: 16];
    ext_data_c = rdata;
    case (funct3)
      F3_LB:   ext_data_c = {{(XLEN-8){byte_c[7]}}, byte_c};
      F3_LBU:  ext_data_c = {{(XLEN-8){1'b0}}, byte_c};
      F3_LH:   ext_data_c = {{(XLEN-16){half_c[15]}}, half_c};
      F3_LHU:  ext_data_c = {{(XLEN-16){1'b0}}, half_c};
      default: ext_data_c = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: stalls the pipeline while one request crosses the
// data bus, with lane steering, load extension, fault detection and bus timeout.
module load_store_unit
  import types_pkg::*;
#(
  parameter int unsigned XLEN           = types_pkg::XLEN,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [2:0]      Funct3M,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ReadDataM,
  output logic            StallM,
  output logic            AccessErrM,
  load_store_unit_if.master bus
);

  localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;
  logic [XLEN-1:0]  rdata_q, rdata_d;
  logic             req_q, req_d;
  logic [XLEN-1:0]  ext_data_c;
  logic             timeout_c;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .rdata      (bus.dmem_rdata),
    .offset     (off_q),
    .funct3     (f3_q),
    .ext_data_c (ext_data_c)
  );

  assign timeout_c = (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    f3_d       = f3_q;
    off_d      = off_q;
    rdata_d    = rdata_q;
    req_d      = 1'b0;
    StallM     = 1'b0;
    AccessErrM = 1'b0;

    case (state_q)
      IDLE: begin
        if (MemReadM || MemWriteM) begin
          if (access_illegal(MemReadM, MemWriteM, Funct3M, ALUResultM[1:0])) begin
            AccessErrM = 1'b1;
            rdata_d    = '0;
          end else begin
            StallM  = 1'b1;
            addr_d  = {ALUResultM[XLEN-1:2], 2'b00};
            be_d    = lane_be(Funct3M, ALUResultM[1:0]);
            we_d    = MemWriteM;
            f3_d    = Funct3M;
            off_d   = ALUResultM[1:0];
            cnt_d   = '0;
            req_d   = 1'b1;
            state_d = REQ;
            // Narrow stores replicate the datum so any lane picked by be sees it.
            case (Funct3M)
              F3_SB:   wdata_d = XLEN'({4{WriteDataM[7:0]}});
              F3_SH:   wdata_d = XLEN'({2{WriteDataM[15:0]}});
              default: wdata_d = WriteDataM;
            endcase
          end
        end
      end

      REQ: begin
        StallM = 1'b1;
        req_d  = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (bus.dmem_gnt) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = we_q ? DONE : WAIT;
        end else if (timeout_c) begin
          req_d      = 1'b0;
          AccessErrM = 1'b1;
          rdata_d    = '0;
          state_d    = DONE;
        end
      end

      WAIT: begin
        StallM = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (bus.dmem_rvalid) begin
          rdata_d = ext_data_c;
          state_d = DONE;
        end else if (timeout_c) begin
          AccessErrM = 1'b1;
          rdata_d    = '0;
          state_d    = DONE;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      rdata_q <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
    end
  end

  assign ReadDataM      = rdata_q;
  assign bus.dmem_req   = req_q;
  assign bus.dmem_we    = we_q;
  assign bus.dmem_addr  = addr_q;
  assign bus.dmem_be    = be_q;
  assign bus.dmem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit with a small responding memory model.
module tb_load_store_unit;
  import types_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  word_t       ALUResultM, WriteDataM, ReadDataM;
  logic        StallM, AccessErrM;

  int n_cmp = 0;
  int n_bad = 0;

  load_store_unit_if #(.XLEN(32)) dmem ();

  load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .AccessErrM (AccessErrM),
    .bus        (dmem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gnt_dly;
    logic        ierr;
    logic        terr;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    int          exp_cyc;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int  cyc;
    int  waited;
    bit  done;
    bit  gnt_prev;
    bit  err_seen;
    @(negedge clk);
    MemReadM   = v.rd;
    MemWriteM  = v.wr;
    Funct3M    = v.f3;
    ALUResultM = v.addr;
    WriteDataM = v.wdata;
    #1;
    check($sformatf("v%0d idle_err", idx), 32'(AccessErrM), 32'(v.ierr));
    check($sformatf("v%0d idle_stall", idx), 32'(StallM), 32'(!v.ierr));
    if (v.ierr) begin
      @(negedge clk);
      MemReadM  = 1'b0;
      MemWriteM = 1'b0;
      #1;
      check($sformatf("v%0d err_req", idx), 32'(dmem.dmem_req), 32'd0);
      check($sformatf("v%0d err_rdata", idx), ReadDataM, v.exp_rdata);
      return;
    end
    cyc = 1; waited = 0; done = 1'b0; gnt_prev = 1'b0; err_seen = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      dmem.dmem_gnt    = 1'b0;
      dmem.dmem_rvalid = 1'b0;
      if (gnt_prev && v.rd) begin
        dmem.dmem_rvalid = 1'b1;
        dmem.dmem_rdata  = v.rdata;
      end
      gnt_prev = 1'b0;
      #1;
      if (!StallM) begin
        done = 1'b1;
      end else begin
        if (AccessErrM) err_seen = 1'b1;
        if (dmem.dmem_req) begin
          check($sformatf("v%0d addr", idx), dmem.dmem_addr, v.exp_addr);
          check($sformatf("v%0d be", idx), 32'(dmem.dmem_be), 32'(v.exp_be));
          if (v.wr) check($sformatf("v%0d wdata", idx), dmem.dmem_wdata, v.exp_wdata);
          if (waited == v.gnt_dly) begin
            dmem.dmem_gnt = 1'b1;
            gnt_prev      = 1'b1;
          end else begin
            waited++;
          end
        end
      end
    end
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    dmem.dmem_gnt    = 1'b0;
    dmem.dmem_rvalid = 1'b0;
    check($sformatf("v%0d finished", idx), 32'(done), 32'd1);
    check($sformatf("v%0d latency", idx), 32'(cyc), 32'(v.exp_cyc));
    check($sformatf("v%0d timeout_err", idx), 32'(err_seen), 32'(v.terr));
    check($sformatf("v%0d done_req", idx), 32'(dmem.dmem_req), 32'd0);
    check($sformatf("v%0d done_err", idx), 32'(AccessErrM), 32'd0);
    check($sformatf("v%0d rdata", idx), ReadDataM, v.exp_rdata);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //          rd    wr    f3      addr          wdata         rdata        dly ie    te    e_addr        e_be     e_wdata       e_rdata      cyc
    vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 1'b0, 1'b0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 3};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,         32'h80FF_FF00, 0, 1'b0, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,         32'hFFFF_FF80, 4};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,         32'h80FF_FF00, 0, 1'b0, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,         32'h0000_0080, 4};
    vecs[3]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h1234_56A5, 32'h0,        0, 1'b0, 1'b0, 32'h0000_0100, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0080, 3};
    vecs[4]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h0,        3, 1'b0, 1'b0, 32'h0000_0100, 4'b1100, 32'h1234_1234, 32'h0000_0080, 6};
    vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,         32'h8001_7F00, 0, 1'b0, 1'b0, 32'h0000_0100, 4'b1100, 32'h0,         32'hFFFF_8001, 4};
    vecs[6]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0200, 32'h0,         32'h1234_F00D, 0, 1'b0, 1'b0, 32'h0000_0200, 4'b0011, 32'h0,         32'h0000_F00D, 4};
    vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0204, 32'h0,         32'hCAFE_F00D, 2, 1'b0, 1'b0, 32'h0000_0204, 4'b1111, 32'h0,         32'hCAFE_F00D, 6};
    vecs[8]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0,         32'h0,        0, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0000_0000, 0};
    vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'h0000_010A, 32'h0,         32'h0,        0, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0000_0000, 0};
    vecs[10] = '{1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0,         32'h0,        0, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0000_0000, 0};
    vecs[11] = '{1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0,         32'h0,        0, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,         32'h0000_0000, 0};
    vecs[12] = '{1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0,         32'h1122_3344, 0, 1'b0, 1'b0, 32'h0000_0300, 4'b1111, 32'h0,         32'h1122_3344, 4};
    vecs[13] = '{1'b1, 1'b0, 3'b010, 32'h0000_0304, 32'h0,         32'h0,       99, 1'b0, 1'b1, 32'h0000_0304, 4'b1111, 32'h0,         32'h0000_0000, 18};
    vecs[14] = '{1'b1, 1'b0, 3'b000, 32'h0000_0002, 32'h0,         32'h007F_0000, 0, 1'b0, 1'b0, 32'h0000_0000, 4'b0100, 32'h0,         32'h0000_007F, 4};

    reset = 1'b0;
    MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = '0; ALUResultM = '0; WriteDataM = '0;
    dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", 32'(StallM), 32'd0);
    check("rst_req", 32'(dmem.dmem_req), 32'd0);
    check("rst_err", 32'(AccessErrM), 32'd0);
    check("rst_rdata", ReadDataM, 32'd0);
    check("rst_addr", dmem.dmem_addr, 32'd0);
    check("rst_be", 32'(dmem.dmem_be), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Reset while waiting for read data: transaction dropped, late rvalid ignored.
    @(negedge clk);
    MemReadM = 1'b1; Funct3M = F3_LW; ALUResultM = 32'h0000_0100;
    @(negedge clk);
    #1;
    check("rstw_req", 32'(dmem.dmem_req), 32'd1);
    dmem.dmem_gnt = 1'b1;
    @(negedge clk);
    dmem.dmem_gnt = 1'b0;
    #1;
    check("rstw_wait_stall", 32'(StallM), 32'd1);
    reset = 1'b0;
    MemReadM = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    dmem.dmem_rvalid = 1'b1;
    dmem.dmem_rdata  = 32'hBAD0_BAD0;
    #1;
    check("rstw_stall", 32'(StallM), 32'd0);
    check("rstw_req0", 32'(dmem.dmem_req), 32'd0);
    check("rstw_err", 32'(AccessErrM), 32'd0);
    check("rstw_rdata", ReadDataM, 32'd0);
    @(negedge clk);
    dmem.dmem_rvalid = 1'b0;
    #1;
    check("rstw_rdata_late", ReadDataM, 32'd0);
    check("rstw_stall_late", 32'(StallM), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width (taken from types_pkg).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, max cycles waiting in any bus state before abort.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports MemReadM  in  1  load in Memory stage, and MemWriteM  in  1  store in Memory stage.
REQ-006 SHALL have ports Funct3M  in  3  access width/sign, and ALUResultM  in  XLEN  byte address.
REQ-007 SHALL have port WriteDataM  in  XLEN  store data, low-aligned.
REQ-008 SHALL have port ReadDataM  out  XLEN  extended load result to writeback.
REQ-009 SHALL have port StallM  out  1  hold F/D/E/M stages, to hazard unit.
REQ-010 SHALL have port AccessErrM  out  1  one-cycle fault pulse (misaligned, illegal, timeout).
REQ-011 SHALL have ports dmem_req  out  1, dmem_we  out  1, dmem_addr  out  XLEN (bits[1:0]=0), dmem_be  out  4, dmem_wdata  out  XLEN.
REQ-012 SHALL have ports dmem_gnt  in  1, dmem_rvalid  in  1, dmem_rdata  in  XLEN.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, WAIT, DONE.
REQ-014 IDLE with legal access: StallM=1 combinationally; latch addr/be/wdata/we/funct3; next REQ.
REQ-015 REQ: dmem_req=1, outputs stable until dmem_gnt; on gnt, store -> DONE, load -> WAIT.
REQ-016 WAIT: dmem_req=0; on dmem_rvalid capture extended data into ReadDataM register -> DONE.
REQ-017 DONE: StallM=0, ReadDataM valid; unconditional -> IDLE; no new request issued from DONE.
REQ-018 Latency: store 3 cycles min (IDLE,REQ,DONE), load 4 cycles min; StallM high in all states but DONE.
REQ-019 Byte lanes: SB be=0001<<a[1:0], wdata byte replicated ×4; SH be=0011<<{a[1],0}, half replicated ×2; SW be=1111.
REQ-020 Loads: 000 LB sign, 001 LH sign, 010 LW, 100 LBU zero, 101 LHU zero; lane selected by latched a[1:0].
REQ-021 Misaligned (half with a[0]=1; word with a[1:0]!=0), funct3 011/110/111, or MemReadM&MemWriteM: no bus request, AccessErrM=1 for that cycle, StallM=0, ReadDataM=0, stay IDLE.
REQ-022 Timeout counter SHALL clear on entry to REQ/WAIT, increment each cycle there; at TIMEOUT_CYCLES-1 without gnt/rvalid: drop dmem_req, AccessErrM=1, ReadDataM=0 -> DONE.
REQ-023 dmem_rvalid in IDLE/REQ/DONE and dmem_gnt outside REQ SHALL be ignored.
REQ-024 ReadDataM SHALL hold last value except when updated in WAIT or zeroed on fault; stores do not alter it.

Reset
REQ-025 reset=0 at clock edge: state IDLE, counter 0, ReadDataM=0, latched regs 0; dmem_req=0, StallM=0, AccessErrM=0 in following cycle.
REQ-026 Reset mid-REQ/WAIT SHALL abandon transaction; late rvalid after reset ignored per REQ-023.

Structure
REQ-027 types_pkg SHALL hold lsu_state_e, funct3 constants (F3_LB..F3_LHU, F3_SB..F3_SW) and word_t.
REQ-028 SHALL instantiate one combinational sub-module load_extend (rdata, offset, funct3 -> extended word).
REQ-029 FSM, counter and latched request SHALL be in load_store_unit; no other submodules.

Verification
REQ-030 SW 0xDEADBEEF @0x100, gnt in REQ cycle 1 -> dmem_addr 0x100, be 1111, StallM high 2 cycles, DONE in cycle 3.
REQ-031 LB @0x103, rdata 0x80FF_FF00 one cycle after gnt -> ReadDataM 0xFFFFFF80; LBU same -> 0x00000080.
REQ-032 LH @0x101 -> no dmem_req, AccessErrM one-cycle pulse, StallM 0, ReadDataM 0.
REQ-033 LW with gnt held 0 for 16 cycles -> abort, AccessErrM pulse, dmem_req drops, return IDLE.
REQ-034 SH 0x1234 @0x102 with gnt after 3 wait cycles -> be 1100, wdata 0x12341234, stable while waiting.
REQ-035 reset low during WAIT, then rvalid -> IDLE, ReadDataM 0, rvalid ignored, no StallM.
